// File: rtl/apb_splitter.sv
// APB 1-to-N splitter: decodes the upper PADDR bits and runs one registered downstream transfer at a time.
// Optional ACCESS-phase timeout with sticky flag is built when APB_TIMEOUT_EN is defined.
module apb_splitter #(
   parameter int N_SLV   = 4,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_W-1:0]       PADDR,
   input  logic [DATA_W-1:0]       PWDATA,
   output logic [DATA_W-1:0]       PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [N_SLV-1:0]        M_PSEL,
   output logic [ADDR_W-1:0]       M_PADDR,
   output logic [DATA_W-1:0]       M_PWDATA,
   output logic                    M_PENABLE,
   output logic                    M_PWRITE,
   input  logic [N_SLV*DATA_W-1:0] M_PRDATA,
   input  logic [N_SLV-1:0]        M_PREADY,
   output logic                    TIMEOUT_FLAG,
   input  logic                    FLAG_CLR,
   output logic                    BUSY
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [N_SLV-1:0]  m_psel_q, m_psel_d;
   logic [ADDR_W-1:0] m_paddr_q, m_paddr_d;
   logic [DATA_W-1:0] m_pwdata_q, m_pwdata_d;
   logic              m_penable_q, m_penable_d;
   logic              m_pwrite_q, m_pwrite_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              keep_q, keep_d;
   logic [SEL_W-1:0]  new_idx;
   logic [N_SLV-1:0]  new_onehot;
   logic [DATA_W-1:0] sel_rdata;
   logic              sel_ready;
   logic              resp_ok;
`ifdef APB_TIMEOUT_EN
   logic [7:0]        cnt_q, cnt_d;
   logic              flag_q, flag_d;
   logic              timeout_hit;
`endif

   assign new_idx = PADDR[ADDR_W-1 -: SEL_W];

   // Slave-side mux: only the currently addressed slave's ready/data matter.
   always_comb begin
      sel_rdata  = '0;
      sel_ready  = 1'b0;
      new_onehot = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (idx_q == SEL_W'(i)) begin
            sel_rdata = M_PRDATA[i*DATA_W +: DATA_W];
            sel_ready = M_PREADY[i];
         end
         if (new_idx == SEL_W'(i)) new_onehot[i] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      m_psel_d    = m_psel_q;
      m_paddr_d   = m_paddr_q;
      m_pwdata_d  = m_pwdata_q;
      m_penable_d = m_penable_q;
      m_pwrite_d  = m_pwrite_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      keep_d      = keep_q;
`ifdef APB_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               m_paddr_d  = PADDR;
               m_pwrite_d = PWRITE;
               m_pwdata_d = PWDATA;
               idx_d      = new_idx;
               rdata_d    = '0;
               keep_d     = 1'b1;
               if (32'(new_idx) < N_SLV) begin
                  m_psel_d = new_onehot;
                  err_d    = 1'b0;
                  state_d  = S_SETUP;
               end else begin
                  err_d    = 1'b1;
                  state_d  = S_RESP;
               end
            end
         end
         S_SETUP: begin
            if (!PSEL) keep_d = 1'b0;
            m_penable_d = 1'b1;
            state_d     = S_ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_d       = 8'd0;
`endif
         end
         S_ACCESS: begin
            // A master that gives up keeps the slave transfer legal but gets no PREADY.
            if (!PSEL) keep_d = 1'b0;
            if (sel_ready) begin
               rdata_d     = m_pwrite_q ? '0 : sel_rdata;
               err_d       = 1'b0;
               m_psel_d    = '0;
               m_penable_d = 1'b0;
               state_d     = S_RESP;
            end
`ifdef APB_TIMEOUT_EN
            else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
               rdata_d     = '0;
               err_d       = 1'b1;
               m_psel_d    = '0;
               m_penable_d = 1'b0;
               timeout_hit = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef APB_TIMEOUT_EN
   always_comb begin
      flag_d = flag_q;
      if (timeout_hit)   flag_d = 1'b1;
      else if (FLAG_CLR) flag_d = 1'b0;
   end
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         m_psel_q    <= '0;
         m_paddr_q   <= '0;
         m_pwdata_q  <= '0;
         m_penable_q <= 1'b0;
         m_pwrite_q  <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         keep_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= 8'd0;
         flag_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         m_psel_q    <= m_psel_d;
         m_paddr_q   <= m_paddr_d;
         m_pwdata_q  <= m_pwdata_d;
         m_penable_q <= m_penable_d;
         m_pwrite_q  <= m_pwrite_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         keep_q      <= keep_d;
`ifdef APB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         flag_q      <= flag_d;
`endif
      end
   end

`ifdef APB_TIMEOUT_EN
   assign TIMEOUT_FLAG = flag_q;
`else
   logic unused_flag_clr;
   assign unused_flag_clr = FLAG_CLR;
   assign TIMEOUT_FLAG    = 1'b0;
`endif

   assign resp_ok   = (state_q == S_RESP) && keep_q && PSEL;
   assign PREADY    = resp_ok;
   assign PRDATA    = resp_ok ? rdata_q : '0;
   assign PSLVERR   = resp_ok && err_q;
   assign M_PSEL    = m_psel_q;
   assign M_PADDR   = m_paddr_q;
   assign M_PWDATA  = m_pwdata_q;
   assign M_PENABLE = m_penable_q;
   assign M_PWRITE  = m_pwrite_q;
   assign BUSY      = (state_q != S_IDLE);

endmodule
